// File: rtl/execute_reg_pkg.sv
// Shared pipeline constants: ALU op codes and forwarding selects.
// Used by decode, the hazard unit and the execute stage.
package execute_reg_pkg;

  localparam int ALU_OP_W = 3;
  localparam int FWD_W    = 2;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_RSV = 2'b11;

endpackage

// File: rtl/execute_reg_if.sv
// Execute-stage bundle: ID/EX inputs, hazard controls and EX/MEM outputs.
// master drives the E side, slave is the execute stage itself.
interface execute_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  import execute_reg_pkg::*;

  logic                stallM;
  logic                flushM;
  logic                RegWriteE;
  logic                MemtoRegE;
  logic                MemWriteE;
  logic                ALUSrcE;
  logic                RegDestE;
  logic [ALU_OP_W-1:0] ALUControlE;
  logic [DATA_W-1:0]   RD1E;
  logic [DATA_W-1:0]   RD2E;
  logic [DATA_W-1:0]   SignImmE;
  logic [REG_AW-1:0]   RtE;
  logic [REG_AW-1:0]   RdE;
  logic [FWD_W-1:0]    ForwardAE;
  logic [FWD_W-1:0]    ForwardBE;
  logic [DATA_W-1:0]   ResultW;

  logic [REG_AW-1:0]   WriteRegE;
  logic                RegWriteM;
  logic                MemtoRegM;
  logic                MemWriteM;
  logic [DATA_W-1:0]   ALUOutM;
  logic [DATA_W-1:0]   WriteDataM;
  logic [REG_AW-1:0]   WriteRegM;

  modport master (
    output stallM, flushM,
    output RegWriteE, MemtoRegE, MemWriteE,
    output ALUSrcE, RegDestE, ALUControlE,
    output RD1E, RD2E, SignImmE,
    output RtE, RdE,
    output ForwardAE, ForwardBE, ResultW,
    input  WriteRegE,
    input  RegWriteM, MemtoRegM, MemWriteM,
    input  ALUOutM, WriteDataM, WriteRegM
  );

  modport slave (
    input  stallM, flushM,
    input  RegWriteE, MemtoRegE, MemWriteE,
    input  ALUSrcE, RegDestE, ALUControlE,
    input  RD1E, RD2E, SignImmE,
    input  RtE, RdE,
    input  ForwardAE, ForwardBE, ResultW,
    output WriteRegE,
    output RegWriteM, MemtoRegM, MemWriteM,
    output ALUOutM, WriteDataM, WriteRegM
  );

endinterface

// File: rtl/execute_reg_alu.sv
// Execute-stage ALU: and/or/add/sub/signed slt, wrapping arithmetic.
// Unassigned op codes produce zero.
module alu
  import execute_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [DATA_W-1:0]   y_o
);

  logic lt;

  assign lt = $signed(a_i) < $signed(b_i);

  always_comb begin
    y_o = '0;
    unique case (1'b1)
      op_i == ALU_AND: y_o = a_i & b_i;
      op_i == ALU_OR:  y_o = a_i | b_i;
      op_i == ALU_ADD: y_o = a_i + b_i;
      op_i == ALU_SUB: y_o = a_i - b_i;
      op_i == ALU_SLT: y_o = {{(DATA_W-1){1'b0}}, lt};
      default:         y_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_reg.sv
// Execute stage: operand forwarding, ALU and the EX/MEM register.
// Flush beats stall; async reset beats both.
module execute_reg
  import execute_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst,
  execute_reg_if.slave bus
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_y;
  logic [REG_AW-1:0] wreg_e;

  logic              rw_q,   rw_d;
  logic              m2r_q,  m2r_d;
  logic              mw_q,   mw_d;
  logic [DATA_W-1:0] alu_q,  alu_d;
  logic [DATA_W-1:0] wd_q,   wd_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;

  always_comb begin
    src_a = bus.RD1E;
    unique case (1'b1)
      bus.ForwardAE == FWD_WB:  src_a = bus.ResultW;
      bus.ForwardAE == FWD_MEM: src_a = alu_q;
      default:                  src_a = bus.RD1E;
    endcase
  end

  always_comb begin
    fwd_b = bus.RD2E;
    unique case (1'b1)
      bus.ForwardBE == FWD_WB:  fwd_b = bus.ResultW;
      bus.ForwardBE == FWD_MEM: fwd_b = alu_q;
      default:                  fwd_b = bus.RD2E;
    endcase
  end

  assign src_b  = bus.ALUSrcE ? bus.SignImmE : fwd_b;
  assign wreg_e = bus.RegDestE ? bus.RdE : bus.RtE;

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i  (src_a),
    .b_i  (src_b),
    .op_i (bus.ALUControlE),
    .y_o  (alu_y)
  );

  always_comb begin
    rw_d   = rw_q;
    m2r_d  = m2r_q;
    mw_d   = mw_q;
    alu_d  = alu_q;
    wd_d   = wd_q;
    wreg_d = wreg_q;
    if (bus.flushM) begin
      rw_d   = 1'b0;
      m2r_d  = 1'b0;
      mw_d   = 1'b0;
      alu_d  = '0;
      wd_d   = '0;
      wreg_d = '0;
    end else if (!bus.stallM) begin
      rw_d   = bus.RegWriteE;
      m2r_d  = bus.MemtoRegE;
      mw_d   = bus.MemWriteE;
      alu_d  = alu_y;
      wd_d   = fwd_b;
      wreg_d = wreg_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      mw_q   <= 1'b0;
      alu_q  <= '0;
      wd_q   <= '0;
      wreg_q <= '0;
    end else begin
      rw_q   <= rw_d;
      m2r_q  <= m2r_d;
      mw_q   <= mw_d;
      alu_q  <= alu_d;
      wd_q   <= wd_d;
      wreg_q <= wreg_d;
    end
  end

  assign bus.WriteRegE  = wreg_e;
  assign bus.RegWriteM  = rw_q;
  assign bus.MemtoRegM  = m2r_q;
  assign bus.MemWriteM  = mw_q;
  assign bus.ALUOutM    = alu_q;
  assign bus.WriteDataM = wd_q;
  assign bus.WriteRegM  = wreg_q;

endmodule

// File: doc/execute_reg.md
EXECUTE_REG -- requirements
Module: execute_reg

Interface
REQ-001 Parameter DATA_W, default 32, sets the datapath width.
REQ-002 Parameter REG_AW, default 5, sets the register-address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 stallM  in  1  hold the EX/MEM register contents.
REQ-006 flushM  in  1  load a bubble into the EX/MEM register.
REQ-007 RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDestE  in  1 each  control bits from the ID/EX register.
REQ-008 ALUControlE  in  3  ALU operation select.
REQ-009 RD1E, RD2E, SignImmE  in  DATA_W each  register operands and sign-extended immediate.
REQ-010 RtE, RdE  in  REG_AW each  destination candidates.
REQ-011 ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
REQ-012 ResultW  in  DATA_W  writeback-stage result, used for forwarding.
REQ-013 WriteRegE  out  REG_AW  combinational destination register for the hazard unit.
REQ-014 RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered control bits.
REQ-015 ALUOutM, WriteDataM  out  DATA_W each  registered ALU result and store data.
REQ-016 WriteRegM  out  REG_AW  registered destination register.

Function
REQ-017 SrcA SHALL be selected by ForwardAE: 00 -> RD1E, 01 -> ResultW, 10 -> ALUOutM, 11 -> RD1E.
REQ-018 Forwarded B (fwdB) SHALL be selected by ForwardBE with the same encoding, using RD2E in place of RD1E.
REQ-019 SrcB SHALL be SignImmE when ALUSrcE=1, otherwise fwdB.
REQ-020 WriteRegE SHALL be RdE when RegDestE=1, otherwise RtE.
REQ-021 The ALU SHALL compute: 000 AND; 001 OR; 010 add; 110 subtract (SrcA-SrcB); 111 signed set-less-than (1 or 0, zero-extended); any other code -> 0.
REQ-022 Add and subtract SHALL wrap modulo 2^DATA_W with no overflow flag or trap.
REQ-023 Without stall or flush, each clk edge SHALL load ALU result -> ALUOutM, fwdB -> WriteDataM, WriteRegE -> WriteRegM, and the three control bits -> their M outputs.
REQ-024 Latency from E inputs to M outputs SHALL be exactly one cycle.
REQ-025 With stallM=1 and flushM=0, all M outputs SHALL hold their values.
REQ-026 flushM=1 SHALL zero all M outputs on the next edge, regardless of stallM (flush has priority over stall).
REQ-027 Forwarding with ForwardAE/BE=10 SHALL use the current registered ALUOutM, i.e. a back-to-back dependency resolves in one cycle.

Reset
REQ-028 While rst=0, all M outputs SHALL be 0 immediately, independent of clk.
REQ-029 Reset SHALL have priority over flushM and stallM.
REQ-030 After rst deasserts, the first rising edge SHALL perform a normal load.

Structure
REQ-031 ALU operation codes and the forwarding-select encodings SHALL be constants in the shared pipeline package, used by decode, hazard unit and execute_reg alike.
REQ-032 The ALU SHALL be a separate sub-module named alu, instantiated once; the muxes and EX/MEM register SHALL stay in execute_reg.

Verification
REQ-033 Reset: assert rst mid-cycle with nonzero M state -> all M outputs read 0 before the next edge.
REQ-034 Inputs RD1E=5, RD2E=7, ALUControlE=010, ALUSrcE=0, RegDestE=1, RdE=3 -> one edge later ALUOutM=12, WriteDataM=7, WriteRegM=3.
REQ-035 Inputs RD1E=0x80000000, SignImmE=1, ALUSrcE=1, ALUControlE=111 -> ALUOutM=1; with ALUControlE=110 -> ALUOutM=0x7FFFFFFF.
REQ-036 Forwarding with ALUOutM=9, ResultW=4, ForwardAE=10, ForwardBE=01, ALUControlE=010 -> next ALUOutM=13, WriteDataM=4.
REQ-037 Stall then flush: stallM=1 for 2 cycles -> outputs unchanged; then stallM=1 with flushM=1 -> all M outputs 0.
REQ-038 Wrap: RD1E=0xFFFFFFFF, RD2E=1, add -> ALUOutM=0; ALUControlE=011 -> ALUOutM=0.
